// File: rtl/pong_pkg.sv
// Shared types and constants for the pong game controller: FSM states,
// LED display patterns, winner codes and a ball-position decoder.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SERVE_L,
        ST_SERVE_R,
        ST_TO_R,
        ST_TO_L,
        ST_POINT,
        ST_OVER
    } state_t;

    localparam logic [7:0] LED_OFF     = 8'h00;
    localparam logic [7:0] LED_SERVE_L = 8'h80;
    localparam logic [7:0] LED_SERVE_R = 8'h01;
    localparam logic [7:0] LED_POINT   = 8'hFF;
    localparam logic [7:0] LED_WIN_L   = 8'hF0;
    localparam logic [7:0] LED_WIN_R   = 8'h0F;

    localparam logic [1:0] WIN_NONE  = 2'b00;
    localparam logic [1:0] WIN_LEFT  = 2'b10;
    localparam logic [1:0] WIN_RIGHT = 2'b01;

    localparam logic [2:0] POS_LEFT  = 3'd7;
    localparam logic [2:0] POS_RIGHT = 3'd0;

    function automatic logic [7:0] pos_to_leds(input logic [2:0] pos);
        return 8'b0000_0001 << pos;
    endfunction

endpackage

// File: rtl/pong_score.sv
// Per-player point counter: synchronous clear, saturating increment, and a
// registered flag that is high whenever the count equals WIN_SCORE.
module pong_score #(
    parameter int WIN_SCORE = 7
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_clr,
    input  logic       i_inc,
    output logic [2:0] o_count,
    output logic       o_win
);

    localparam logic [2:0] WIN_VAL = 3'(WIN_SCORE);

    logic [2:0] r_count;
    logic       r_win;
    logic [2:0] w_count_next;

    always_comb begin
        w_count_next = r_count;
        if (i_clr)
            w_count_next = 3'd0;
        else if (i_inc && (r_count != WIN_VAL))
            w_count_next = r_count + 3'd1;
    end

    // Win flag tracks the next count so it is valid in the same cycle as the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 3'd0;
            r_win   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_win   <= (w_count_next == WIN_VAL);
        end
    end

    assign o_count = r_count;
    assign o_win   = r_win;

endmodule

// File: rtl/pong_game_controller.sv
// Eight-LED pong: serve/rally/point/game-over FSM with ball position, rally
// speed code and registered display outputs; scores held in two pong_score counters.
module pong_game_controller
    import pong_pkg::*;
#(
    parameter int         WIN_SCORE  = 7,
    parameter logic [3:0] SPEED_INIT = 4'd0,
    parameter logic [3:0] SPEED_MAX  = 4'd15
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    input  logic       i_start,
    output logic [3:0] o_speed,
    output logic [7:0] o_leds,
    output logic [2:0] o_score_l,
    output logic [2:0] o_score_r,
    output logic [1:0] o_winner
);

    state_t     r_state;
    logic [2:0] r_pos;
    logic [3:0] r_speed;
    logic [7:0] r_leds;
    logic [1:0] r_winner;
    logic       r_left_scored;

    logic w_clr, w_inc_l, w_inc_r, w_win_l, w_win_r;
    logic w_window_r, w_window_l;

    assign w_window_r = (r_state == ST_TO_R) && (r_pos == POS_RIGHT);
    assign w_window_l = (r_state == ST_TO_L) && (r_pos == POS_LEFT);
    assign w_clr      = i_start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    // A press in the same cycle as the closing Tick still counts as a hit.
    assign w_inc_l    = w_window_r && i_tick && !i_btn_r;
    assign w_inc_r    = w_window_l && i_tick && !i_btn_l;

    pong_score #(.WIN_SCORE(WIN_SCORE)) u_score_l (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc_l),
        .o_count (o_score_l),
        .o_win   (w_win_l)
    );

    pong_score #(.WIN_SCORE(WIN_SCORE)) u_score_r (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_inc   (w_inc_r),
        .o_count (o_score_r),
        .o_win   (w_win_r)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_pos         <= POS_LEFT;
            r_speed       <= SPEED_INIT;
            r_leds        <= LED_OFF;
            r_winner      <= WIN_NONE;
            r_left_scored <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (i_start) begin
                        r_state  <= ST_SERVE_L;
                        r_pos    <= POS_LEFT;
                        r_speed  <= SPEED_INIT;
                        r_leds   <= LED_SERVE_L;
                        r_winner <= WIN_NONE;
                    end
                end
                ST_SERVE_L: if (i_btn_l) r_state <= ST_TO_R;
                ST_SERVE_R: if (i_btn_r) r_state <= ST_TO_L;
                ST_TO_R: begin
                    if (w_window_r) begin
                        if (i_btn_r) begin
                            r_state <= ST_TO_L;
                            if (r_speed != SPEED_MAX) r_speed <= r_speed + 4'd1;
                        end else if (i_tick) begin
                            r_state       <= ST_POINT;
                            r_leds        <= LED_POINT;
                            r_left_scored <= 1'b1;
                        end
                    end else if (i_tick) begin
                        r_pos  <= r_pos - 3'd1;
                        r_leds <= pos_to_leds(r_pos - 3'd1);
                    end
                end
                ST_TO_L: begin
                    if (w_window_l) begin
                        if (i_btn_l) begin
                            r_state <= ST_TO_R;
                            if (r_speed != SPEED_MAX) r_speed <= r_speed + 4'd1;
                        end else if (i_tick) begin
                            r_state       <= ST_POINT;
                            r_leds        <= LED_POINT;
                            r_left_scored <= 1'b0;
                        end
                    end else if (i_tick) begin
                        r_pos  <= r_pos + 3'd1;
                        r_leds <= pos_to_leds(r_pos + 3'd1);
                    end
                end
                ST_POINT: begin
                    if (i_tick) begin
                        if (w_win_l || w_win_r) begin
                            r_state  <= ST_OVER;
                            r_leds   <= w_win_l ? LED_WIN_L : LED_WIN_R;
                            r_winner <= w_win_l ? WIN_LEFT : WIN_RIGHT;
                        end else begin
                            r_speed <= SPEED_INIT;
                            // The player who lost the point serves next.
                            if (r_left_scored) begin
                                r_state <= ST_SERVE_R;
                                r_pos   <= POS_RIGHT;
                                r_leds  <= LED_SERVE_R;
                            end else begin
                                r_state <= ST_SERVE_L;
                                r_pos   <= POS_LEFT;
                                r_leds  <= LED_SERVE_L;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_speed  = r_speed;
    assign o_leds   = r_leds;
    assign o_winner = r_winner;

endmodule

// File: tb/tb_pong_game_controller.sv
// Directed bench for pong_game_controller: a behavioural model pushes expected
// outputs per cycle to a queue, popped and compared after each clock edge.
module tb_pong_game_controller;

    localparam int S_IDLE = 0, S_SL = 1, S_SR = 2, S_TR = 3, S_TL = 4, S_PT = 5, S_OV = 6;

    typedef struct packed {
        logic [7:0] leds;
        logic [3:0] speed;
        logic [2:0] sl;
        logic [2:0] sr;
        logic [1:0] win;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, btn_l = 1'b0, btn_r = 1'b0, start = 1'b0;
    logic [3:0] speed;
    logic [7:0] leds;
    logic [2:0] score_l, score_r;
    logic [1:0] winner;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t q[$];

    int       m_st = S_IDLE;
    int       m_pos = 7;
    int       m_speed = 0;
    int       m_sl = 0, m_sr = 0;
    logic [1:0] m_wn = 2'b00;
    bit       m_lastl = 1'b0;

    always #5 clk = ~clk;

    pong_game_controller dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_tick    (tick),
        .i_btn_l   (btn_l),
        .i_btn_r   (btn_r),
        .i_start   (start),
        .o_speed   (speed),
        .o_leds    (leds),
        .o_score_l (score_l),
        .o_score_r (score_r),
        .o_winner  (winner)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_pos = 7; m_speed = 0; m_sl = 0; m_sr = 0; m_wn = 2'b00; m_lastl = 1'b0;
    endtask

    task automatic model_step(input bit t, input bit l, input bit r, input bit s);
        case (m_st)
            S_IDLE, S_OV: if (s) begin
                m_st = S_SL; m_pos = 7; m_sl = 0; m_sr = 0; m_speed = 0; m_wn = 2'b00;
            end
            S_SL: if (l) m_st = S_TR;
            S_SR: if (r) m_st = S_TL;
            S_TR: begin
                if (m_pos == 0) begin
                    if (r) begin m_st = S_TL; if (m_speed < 15) m_speed++; end
                    else if (t) begin if (m_sl < 7) m_sl++; m_lastl = 1'b1; m_st = S_PT; end
                end else if (t) m_pos--;
            end
            S_TL: begin
                if (m_pos == 7) begin
                    if (l) begin m_st = S_TR; if (m_speed < 15) m_speed++; end
                    else if (t) begin if (m_sr < 7) m_sr++; m_lastl = 1'b0; m_st = S_PT; end
                end else if (t) m_pos++;
            end
            S_PT: if (t) begin
                if (m_sl == 7 || m_sr == 7) begin
                    m_st = S_OV; m_wn = (m_sl == 7) ? 2'b10 : 2'b01;
                end else begin
                    m_speed = 0;
                    if (m_lastl) begin m_st = S_SR; m_pos = 0; end
                    else begin m_st = S_SL; m_pos = 7; end
                end
            end
            default: ;
        endcase
    endtask

    function automatic exp_t model_out();
        exp_t e;
        case (m_st)
            S_IDLE:     e.leds = 8'h00;
            S_SL:       e.leds = 8'h80;
            S_SR:       e.leds = 8'h01;
            S_TR, S_TL: e.leds = 8'(1 << m_pos);
            S_PT:       e.leds = 8'hFF;
            default:    e.leds = (m_wn == 2'b10) ? 8'hF0 : 8'h0F;
        endcase
        e.speed = 4'(m_speed);
        e.sl    = 3'(m_sl);
        e.sr    = 3'(m_sr);
        e.win   = m_wn;
        return e;
    endfunction

    task automatic cyc(input bit t, input bit l, input bit r, input bit s);
        exp_t e;
        tick = t; btn_l = l; btn_r = r; start = s;
        model_step(t, l, r, s);
        q.push_back(model_out());
        @(posedge clk);
        #1;
        tick = 1'b0; btn_l = 1'b0; btn_r = 1'b0; start = 1'b0;
        if (q.size() == 0) begin
            chk("queue_empty", 16'd0, 16'd1);
        end else begin
            e = q.pop_front();
            chk("leds",    16'(leds),    16'(e.leds));
            chk("speed",   16'(speed),   16'(e.speed));
            chk("score_l", 16'(score_l), 16'(e.sl));
            chk("score_r", 16'(score_r), 16'(e.sr));
            chk("winner",  16'(winner),  16'(e.win));
        end
        $display("cyc t=%0b l=%0b r=%0b s=%0b -> leds=%02h speed=%0d L=%0d R=%0d win=%02b",
                 t, l, r, s, leds, speed, score_l, score_r, winner);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Plays until the point is decided, then the POINT tick; the losing side never returns.
    task automatic play_point(input bit left_wins);
        int guard = 0;
        while (m_st != S_PT && guard < 200) begin
            guard++;
            if (m_st == S_SL)                    cyc(1'b0, 1'b1, 1'b0, 1'b0);
            else if (m_st == S_SR)               cyc(1'b0, 1'b0, 1'b1, 1'b0);
            else if (m_st == S_TL && m_pos == 7) cyc(1'b1, left_wins, 1'b0, 1'b0);
            else if (m_st == S_TR && m_pos == 0) cyc(1'b1, 1'b0, !left_wins, 1'b0);
            else                                 cyc(1'b1, 1'b0, 1'b0, 1'b0);
        end
        if (guard >= 200) chk("play_point_timeout", 16'(guard), 16'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic play_game(input bit left_wins);
        int guard = 0;
        while (m_st != S_OV && guard < 20) begin
            guard++;
            play_point(left_wins);
        end
        if (guard >= 20) chk("play_game_timeout", 16'(guard), 16'd0);
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_leds",   16'(leds),    16'h00);
        chk("rst_speed",  16'(speed),   16'd0);
        chk("rst_score",  16'({score_l, score_r}), 16'd0);
        chk("rst_winner", 16'(winner),  16'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Nothing moves without Start
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 1);
        chk("start_leds", 16'(leds), 16'h80);
        cyc(1, 0, 1, 0);
        cyc(0, 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            cyc(1, 0, 0, 0);
            chk("leds_step", 16'(leds), 16'(8'h80 >> k));
        end
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        chk("first_hit_speed", 16'(speed), 16'd1);

        // Back to left, hit, then ignored presses and a right-side miss
        ticks(7);
        cyc(0, 1, 0, 0);
        ticks(4);
        chk("pos3_leds", 16'(leds), 16'h08);
        cyc(0, 0, 1, 0);
        ticks(3);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("miss_score_l", 16'(score_l), 16'd1);
        chk("miss_leds",    16'(leds),    16'hFF);
        cyc(1, 0, 0, 0);
        chk("serve_r_leds",  16'(leds),  16'h01);
        chk("serve_r_speed", 16'(speed), 16'd0);

        // Serve right; same-cycle Tick and BtnR at the window is a hit
        cyc(0, 0, 1, 0);
        ticks(7);
        cyc(0, 1, 0, 0);
        ticks(7);
        cyc(1, 0, 1, 0);
        chk("same_cycle_hit_score", 16'(score_l), 16'd1);
        chk("same_cycle_hit_speed", 16'(speed),   16'd2);

        // 16 consecutive hits saturate the speed code
        for (int h = 0; h < 16; h++) begin
            ticks(7);
            if (m_st == S_TL) cyc(0, 1, 0, 0);
            else              cyc(0, 0, 1, 0);
        end
        chk("speed_saturated", 16'(speed), 16'd15);

        play_game(1'b1);
        chk("over_l_leds",   16'(leds),    16'hF0);
        chk("over_l_winner", 16'(winner),  16'b10);
        chk("over_l_score",  16'(score_l), 16'd7);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 1);
        chk("restart_scores", 16'({score_l, score_r}), 16'd0);
        chk("restart_winner", 16'(winner), 16'd0);

        play_game(1'b0);
        chk("over_r_leds",   16'(leds),   16'h0F);
        chk("over_r_winner", 16'(winner), 16'b01);
        cyc(0, 0, 0, 1);

        // Reset mid-rally at pos 4
        play_point(1'b1);
        cyc(0, 0, 1, 0);
        ticks(4);
        chk("pos4_leds", 16'(leds), 16'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_leds",  16'(leds),  16'h00);
        chk("async_rst_score", 16'({score_l, score_r}), 16'd0);
        chk("async_rst_speed", 16'(speed), 16'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc(1, 1, 0, 0);
        cyc(1, 0, 1, 0);
        chk("post_rst_idle", 16'(leds), 16'h00);
        cyc(0, 0, 0, 1);
        chk("post_rst_start", 16'(leds), 16'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
